pipeline_reg_multistore: RTL
============================

Name: pipeline_reg_multistore

Overview:
- Parametrised latency-insensitive pipeline buffer. Successor to the single-store pipeline register.
- Holds up to Depth tokens in a circular buffer and sustains one token per cycle when Depth>=2.
- Optional zero-latency bypass when empty.
- Reports occupancy.
- Sits between any two LI stages using valid/backpressure handshakes; bp high means stall.

Parameters:
- Width, 8, token data width in bits.
- Depth, 2, number of storage entries. Must be >=1; Depth=0 is illegal and must fail elaboration.
- Bypass, 0, 1 = combinational pass-through when empty. 0 = always registered.

Ports:
- clk  input  1  clock; all state updates on posedge.
- resetn  input  1  synchronous, active-low reset.
- d  input  Width  incoming token data.
- d_valid  input  1  incoming token present.
- d_bp  output  1  backpressure to producer; high = token not accepted this cycle.
- q  output  Width  outgoing token data.
- q_valid  output  1  outgoing token present.
- q_bp  input  1  backpressure from consumer.
- count  output  $clog2(Depth+1)  number of tokens currently stored. Does not include a bypassed token.

Behaviour:
- State:
  - mem[Depth] of Width bits.
  - rd_ptr and wr_ptr, each clog2(Depth) bits, minimum 1 bit.
  - count register.
- Reset (resetn low at posedge):
  - count=0, rd_ptr=0, wr_ptr=0. mem is not reset.
  - After reset: q_valid=0, d_bp=0, count=0.
  - Reset mid-operation silently drops all stored tokens.
  - A token offered in the reset cycle is discarded.
- d_bp = (count == Depth), driven from registered state only. There is no combinational path from q_bp to d_bp.
  - When full, a simultaneous dequeue still does not allow an enqueue in the same cycle.
  - Consequence: Depth=1 gives 50% throughput; Depth>=2 gives full throughput.
- Handshake terms:
  - accept = d_valid & ~d_bp.
  - take = q_valid & ~q_bp.
- Bypass=0:
  - q = mem[rd_ptr]; q_valid = (count != 0).
  - Minimum latency 1 cycle.
  - On accept: write d to mem[wr_ptr], advance wr_ptr.
  - On take: advance rd_ptr.
- Bypass=1, count==0:
  - q = d, q_valid = d_valid.
  - If d_valid & ~q_bp: token passes through with 0-cycle latency. It is not written and count is unchanged.
  - If d_valid & q_bp: token is written to mem (accept) and appears registered from the next cycle.
- Bypass=1, count!=0: identical to Bypass=0. Ordering is preserved because a new token is always queued behind stored ones.
- Pointer wrap: when a pointer equals Depth-1 and advances, it returns to 0. Depth need not be a power of two.
- Count update: count_next = count + store - pop.
  - store = accept and not bypassed.
  - pop = take from storage.
  - Simultaneous store and pop leaves count unchanged; both pointers advance.
- Stability rule: while q_valid & q_bp, q and q_valid hold their values.
  - In bypass mode this relies on the producer holding d stable. This is the LI producer obligation while d_valid & d_bp. Here d_bp=0, so the token is captured that cycle.
- FIFO order: tokens exit in acceptance order; no token is duplicated or lost except at reset.
- Producer ignoring d_bp while full: the token is not accepted and mem is not written.

Test Plan:
- Reset, then idle with Width=8, Depth=2, Bypass=0 -> q_valid=0, d_bp=0, count=0 in every cycle. Offering d=0x5A in the reset cycle is dropped: q_valid stays 0 afterwards.
- Streaming, Depth=2, Bypass=0, q_bp=0, d_valid=1 each cycle with d=0,1,2,...,99 -> q emits 0..99 in order, each exactly one cycle after it is offered. d_bp is never asserted. count stays <=1.
- Fill and wrap, Depth=3, q_bp=1, offer 0xA1,0xA2,0xA3,0xA4:
  - count reaches 3 and d_bp=1. 0xA4 is held by the producer.
  - Release q_bp for one cycle -> 0xA1 leaves. d_bp stays 1 that cycle and drops the next.
  - 0xA4 is written at wrapped index 0. Final drain order is A2,A3,A4.
- Full with simultaneous events, Depth=1: continuous d_valid, q_bp=0 -> one token every 2 cycles. Alternating d_bp=1/0 with count toggling 1/0.
- Bypass=1, Depth=2:
  - Empty, q_bp=0, d=0x33 valid -> q=0x33, q_valid=1 in the same cycle; count stays 0.
  - Then q_bp=1, d=0x44 -> stored, count=1, q=0x44 from the next cycle.
  - Then d=0x55 with q_bp=0 -> q shows 0x44 first, then 0x55.
- Reset mid-operation with count=2, Depth=4 -> next cycle count=0, q_valid=0. Subsequent tokens 0x10,0x11 exit correctly from pointer 0.

Source files
------------

// File: rtl/pipeline_reg_multistore.sv
// pipeline_reg_multistore: latency-insensitive buffer holding up to Depth
// tokens in a circular store, with an optional zero-latency bypass when empty.
// Backpressure to the producer depends only on registered occupancy.
module pipeline_reg_multistore #(
  parameter int Width  = 8,
  parameter int Depth  = 2,
  parameter int Bypass = 0
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [Width-1:0]           d,
  input  logic                       d_valid,
  output logic                       d_bp,
  output logic [Width-1:0]           q,
  output logic                       q_valid,
  input  logic                       q_bp,
  output logic [$clog2(Depth+1)-1:0] count
);

  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntW = $clog2(Depth + 1);
  localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);
  localparam logic [PtrW-1:0] LastPtr  = PtrW'(Depth - 1);

  // A zero-entry buffer has no meaning; refuse to build one.
  if (Depth < 1) begin : g_bad_depth
    $error("pipeline_reg_multistore: Depth must be >= 1");
  end

  // Circular advance that tolerates non-power-of-two depths.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    logic [PtrW-1:0] r;
    if (p == LastPtr) begin
      r = {PtrW{1'b0}};
    end else begin
      r = p + PtrW'(1);
    end
    return r;
  endfunction

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]  count_q,  count_d;

  logic             empty_s;
  logic             full_s;
  logic             bypass_s;
  logic [Width-1:0] head_s;
  logic             accept_s;
  logic             take_s;
  logic             passthru_s;
  logic             store_s;
  logic             pop_s;

  // Head-of-store read, done by compare so any depth indexes cleanly.
  always_comb begin
    head_s = {Width{1'b0}};
    for (int i = 0; i < Depth; i++) begin
      if (rd_ptr_q == PtrW'(i)) begin
        head_s = mem_q[i];
      end else begin
        head_s = head_s;
      end
    end
  end

  // Output selection and handshake decode.
  always_comb begin
    empty_s  = (count_q == {CntW{1'b0}});
    full_s   = (count_q == DepthCnt);
    bypass_s = (Bypass != 0) && empty_s;
    d_bp     = full_s;
    if (bypass_s) begin
      q       = d;
      q_valid = d_valid;
    end else begin
      q       = head_s;
      q_valid = !empty_s;
    end
    accept_s   = d_valid && !full_s;
    take_s     = q_valid && !q_bp;
    // A token taken while bypassing never touches storage.
    passthru_s = bypass_s && take_s;
    store_s    = accept_s && !passthru_s;
    pop_s      = take_s && !bypass_s;
    count      = count_q;
  end

  // Next-state for pointers, occupancy and storage.
  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < Depth; i++) begin
      if (store_s && (wr_ptr_q == PtrW'(i))) begin
        mem_d[i] = d;
      end else begin
        mem_d[i] = mem_q[i];
      end
    end

    if (store_s) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({store_s, pop_s})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state with synchronous active-low reset; stored tokens are dropped.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_ptr_q <= {PtrW{1'b0}};
      wr_ptr_q <= {PtrW{1'b0}};
      count_q  <= {CntW{1'b0}};
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Token storage is not reset; validity comes from count alone.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule
